// File: rtl/jpeg2bmp_pkg.sv
// jpeg2bmp_pkg
//   Shared constants and types for the JPEG decoder dequantisation stage.
//   - BLK_N     : coefficients per 8x8 block
//   - COEF_W    : coefficient / quant entry / product width
//   - coef_t    : signed coefficient type
//   - state_t   : dequant block states (fill from decoder, drain to IDCT)
//   - ZZ_TO_NAT : zigzag position -> natural (row*8+col) index
package jpeg2bmp_pkg;

  localparam int BLK_N  = 64;
  localparam int COEF_W = 16;

  typedef logic signed [15:0] coef_t;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [5:0] ZZ_TO_NAT [0:63] = '{
     6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/jpeg2bmp_dequant_block_mul.sv
// jpeg2bmp_mul_16s_16s_16_1_1
//   Combinational signed multiplier, result truncated to dout_WIDTH bits
//   (two's-complement wrap, no saturation).
//   - din0 : signed multiplicand
//   - din1 : signed multiplier
//   - dout : low dout_WIDTH bits of din0*din1
module jpeg2bmp_mul_16s_16s_16_1_1 #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Only the low bits are kept, so the full-width product is never needed.
  assign dout = dout_WIDTH'($signed(din0) * $signed(din1));

endmodule

// File: rtl/jpeg2bmp_dequant_block.sv
// jpeg2bmp_dequant_block
//   Dequantises one 8x8 block of zigzag-ordered coefficients, stores the
//   products in natural order, then streams them out to the IDCT.
//   - ap_clk / ap_rst_n          : clock, async active-low reset
//   - qt_we / qt_addr / qt_data  : quant-table write port (zigzag index)
//   - in_coef / in_valid / in_ready : zigzag coefficient input
//   - out_coef / out_idx / out_valid / out_ready / out_last :
//                                  natural-order output stream
module jpeg2bmp_dequant_block
  import jpeg2bmp_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              qt_we,
  input  logic [5:0]        qt_addr,
  input  logic [COEF_W-1:0] qt_data,
  input  logic [COEF_W-1:0] in_coef,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [5:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  state_t     state_q, state_d;
  logic [5:0] wr_k_q, wr_k_d;
  logic [5:0] rd_n_q, rd_n_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic [5:0] out_idx_q, out_idx_d;

  coef_t qt_q  [BLK_N];
  coef_t buf_q [BLK_N];

  logic        accept;
  logic        handshake;
  logic [15:0] qt_rd;
  logic [15:0] prod;
  logic [5:0]  wr_nat;

  // in_ready_q is only high in FILL and out_valid_q only in DRAIN, so the
  // handshakes need no separate state qualification.
  assign accept    = in_valid & in_ready_q;
  assign handshake = out_valid_q & out_ready;

  // Combinational table read: a same-cycle qt write lands on the edge, so
  // the product always uses the entry held before that edge.
  assign qt_rd  = qt_q[wr_k_q];
  assign wr_nat = ZZ_TO_NAT[wr_k_q];

  jpeg2bmp_mul_16s_16s_16_1_1 #(
    .din0_WIDTH(16),
    .din1_WIDTH(16),
    .dout_WIDTH(16)
  ) u_mul (
    .din0(in_coef),
    .din1(qt_rd),
    .dout(prod)
  );

  always_comb begin
    state_d     = state_q;
    wr_k_d      = wr_k_q;
    rd_n_d      = rd_n_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_k_d = wr_k_q + 6'd1;
          if (wr_k_q == 6'd63) begin
            state_d     = ST_DRAIN;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_idx_d   = rd_n_q;
            out_last_d  = (rd_n_q == 6'd63);
          end
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          rd_n_d     = rd_n_q + 6'd1;
          out_idx_d  = rd_n_q + 6'd1;
          out_last_d = (rd_n_q == 6'd62);
          if (rd_n_q == 6'd63) begin
            state_d     = ST_FILL;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_idx_d   = 6'd0;
            out_last_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_FILL;
      wr_k_q      <= 6'd0;
      rd_n_q      <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= 6'd0;
    end else begin
      state_q     <= state_d;
      wr_k_q      <= wr_k_d;
      rd_n_q      <= rd_n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
    end
  end

  // Quant table: writable in any state, reset to unity gain.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < BLK_N; i++) qt_q[i] <= 16'sd1;
    end else if (qt_we) begin
      qt_q[qt_addr] <= qt_data;
    end
  end

  // Block buffer in natural order; cleared on reset so a discarded partial
  // block never leaks into the output.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < BLK_N; i++) buf_q[i] <= 16'sd0;
    end else if (accept) begin
      buf_q[wr_nat] <= prod;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_coef  = buf_q[rd_n_q];

endmodule

// File: tb/tb_jpeg2bmp_dequant_block.sv
// tb_jpeg2bmp_dequant_block
//   Directed bench for the dequant/de-zigzag stage. Expected output blocks
//   are written by hand in natural order for each scenario.
module tb_jpeg2bmp_dequant_block;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        qt_we;
  logic [5:0]  qt_addr;
  logic [15:0] qt_data;
  logic [15:0] in_coef;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_coef;
  logic [5:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int n_checks;
  int n_errors;

  logic [15:0] coef_v [64];  // stimulus, zigzag order
  logic [15:0] exp_v  [64];  // expected, natural order

  jpeg2bmp_dequant_block #(.COEF_W(16)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .qt_we    (qt_we),
    .qt_addr  (qt_addr),
    .qt_data  (qt_data),
    .in_coef  (in_coef),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_coef (out_coef),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_block(input logic [15:0] fill_val, input logic [15:0] exp_val);
    for (int i = 0; i < 64; i++) begin
      coef_v[i] = fill_val;
      exp_v[i]  = exp_val;
    end
  endtask

  task automatic load_qt(input logic [15:0] val);
    for (int k = 0; k < 64; k++) begin
      qt_we = 1'b1; qt_addr = 6'(k); qt_data = val;
      step();
    end
    qt_we = 1'b0;
  endtask

  // Feed n_acc coefficients; optionally write qt[we_k] in the cycle of that accept.
  task automatic fill(input int n_acc, input int we_k, input logic [15:0] we_d);
    for (int k = 0; k < n_acc; k++) begin
      check("fill_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_coef  = coef_v[k];
      if (k == we_k) begin
        qt_we = 1'b1; qt_addr = 6'(k); qt_data = we_d;
      end
      step();
      qt_we = 1'b0;
    end
    in_valid = 1'b0;
    if (n_acc == 64) begin
      check("post_fill_out_valid", out_valid, 1);
      check("post_fill_in_ready", in_ready, 0);
      check("post_fill_out_idx", out_idx, 0);
    end
  endtask

  // Drain 64 outputs with stall_pct percent of cycles holding out_ready low.
  task automatic drain(input int stall_pct);
    int n = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [15:0] held_c = '0;
    logic [5:0]  held_i = '0;
    while (n < 64 && cyc < 2000) begin
      if (stalled) begin
        check("stall_hold_idx", out_idx, held_i);
        check("stall_hold_coef", out_coef, held_c);
      end
      check("drain_out_valid", out_valid, 1);
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_ready) begin
        check("drain_idx", out_idx, n);
        check("drain_coef", out_coef, exp_v[n]);
        check("drain_last", out_last, (n == 63));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_c  = out_coef;
        held_i  = out_idx;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", n, 64);
    check("post_drain_in_ready", in_ready, 1);
    check("post_drain_out_valid", out_valid, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    ap_rst_n  = 1'b0;
    qt_we     = 1'b0;
    qt_addr   = '0;
    qt_data   = '0;
    in_coef   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    ap_rst_n = 1'b1;
    step();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_coef", out_coef, 0);

    // All ones with default qt; in_valid held high in DRAIN must be ignored.
    set_block(16'd1, 16'd1);
    fill(64, -1, 16'd0);
    in_valid = 1'b1;
    in_coef  = 16'h7777;
    drain(0);
    in_valid = 1'b0;

    // qt=16, zigzag k=2 (natural 8) = -3 -> 0xFFD0
    load_qt(16'd16);
    set_block(16'd0, 16'd0);
    coef_v[2] = 16'hFFFD;
    exp_v[8]  = 16'hFFD0;
    fill(64, -1, 16'd0);
    drain(0);

    // 300*300 = 90000 wraps to 0x5F90
    qt_we = 1'b1; qt_addr = 6'd0; qt_data = 16'd300;
    step();
    qt_we = 1'b0;
    set_block(16'd0, 16'd0);
    coef_v[0] = 16'd300;
    exp_v[0]  = 16'h5F90;
    fill(64, -1, 16'd0);
    drain(0);

    // Stalled drain: qt[0]=300, others 16; coef 2 -> 600 at idx 0, 32 elsewhere
    set_block(16'd2, 16'd32);
    exp_v[0] = 16'd600;
    fill(64, -1, 16'd0);
    drain(30);

    // Reset in the middle of a fill
    set_block(16'd5, 16'd0);
    fill(20, -1, 16'd0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_coef", out_coef, 0);
    step();
    ap_rst_n = 1'b1;
    step();
    set_block(16'd7, 16'd7);  // qt back to 1
    fill(64, -1, 16'd0);
    drain(0);

    // Same-cycle qt write at k=5 (natural 2): old entry 1 then new entry 9
    set_block(16'd0, 16'd0);
    coef_v[5] = 16'd10;
    exp_v[2]  = 16'd10;
    fill(64, 5, 16'd9);
    drain(0);
    exp_v[2]  = 16'd90;
    fill(64, -1, 16'd0);
    drain(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jpeg2bmp_dequant_block.md
# jpeg2bmp_dequant_block

Dequantisation and de-zigzag stage of the JPEG decoder. It accepts one 8x8 block of Huffman-decoded coefficients in zigzag order and multiplies each coefficient by its quantisation-table entry. It uses the existing `jpeg2bmp_mul_16s_16s_16_1_1` signed multiplier for this. Results are stored in natural (raster) order and then streamed to the IDCT stage.

## Interface
Parameters:
- `COEF_W`, 16: coefficient, quant-entry and product width. Fixed at 16 to match the multiplier.

Ports:
- `ap_clk`, in, 1: sole clock. All state updates on the rising edge.
- `ap_rst_n`, in, 1: reset, asynchronous and active-low.
- `qt_we`, in, 1: quant-table write strobe.
- `qt_addr`, in, 6: quant-table index, in zigzag order.
- `qt_data`, in, 16: quant-table entry, signed.
- `in_coef`, in, 16: signed coefficient, in zigzag order.
- `in_valid`, in, 1: coefficient valid.
- `in_ready`, out, 1: stage can accept a coefficient.
- `out_coef`, out, 16: dequantised coefficient, in natural order.
- `out_idx`, out, 6: natural index (row*8+col) of `out_coef`.
- `out_valid`, out, 1: output valid.
- `out_ready`, in, 1: downstream accepts.
- `out_last`, out, 1: high together with `out_idx`==63.

## Operation
- State FILL:
  - `in_ready`=1 and `out_valid`=0.
  - Each cycle with `in_valid`&`in_ready` is an accept: buffer[ZZ_TO_NAT[wr_k]] <= low 16 bits of `in_coef`*qt[wr_k], and `wr_k` increments.
  - The accept with `wr_k`==63 sets `wr_k` to 0 and moves the state to DRAIN.
- State DRAIN:
  - `in_ready`=0 and `out_valid`=1.
  - `out_idx`=`rd_n` and `out_coef`=buffer[`rd_n`].
  - Each cycle with `out_valid`&`out_ready` increments `rd_n`.
  - The handshake at `rd_n`==63 sets `rd_n` to 0 and moves the state to FILL.
- Arithmetic:
  - Product is signed 16x16 truncated to the low 16 bits, with two's-complement wrap. There is no saturation.
  - `in_coef`=0 still performs the write.
- Quant table:
  - 64x16 register array, writable in any state.
  - If `qt_we` targets the same index that an accept reads in the same cycle, the multiply uses the old entry and the new entry is stored.
- Output stability: `out_coef` and `out_idx` hold while `out_valid`&!`out_ready`.
- Reset values:
  - State = FILL.
  - `wr_k`=0 and `rd_n`=0.
  - `in_ready`=1, `out_valid`=0, `out_last`=0.
  - `out_idx`=0 and `out_coef`=0.
  - Buffer cleared to 0.
  - All qt entries = 16'd1.
- Reset mid-block discards the partial block and returns to the reset state. Quant-table contents are also reset.

## Timing
- `in_ready`, `out_valid`, `out_idx` and `out_last` come straight from registers.
- `out_coef` is a combinational read of the buffer at `rd_n`.
- Input to buffer: the product is written on the accept edge.
- Block latency:
  - `out_valid` rises the cycle after the 64th accept.
  - Minimum period is 128 cycles per block: 64 fill plus 64 drain.
- `in_ready` falls the cycle after the 64th accept. `in_valid` in DRAIN is ignored, and no data is consumed.
- `out_valid` falls the cycle after the 64th output handshake, and `in_ready` rises in that same cycle.
- Stall in DRAIN with `out_ready`=0 holds all state indefinitely.

## Structure
- Package `jpeg2bmp_pkg` holds:
  - `BLK_N`=64.
  - `COEF_W`=16.
  - Type `coef_t` = logic signed [15:0].
  - Constant array `ZZ_TO_NAT[0:63]`, the standard JPEG zigzag-to-natural map: 0,1,8,16,9,2,3,10,…,63.
- One sub-module: instance `u_mul` of `jpeg2bmp_mul_16s_16s_16_1_1` with `din0_WIDTH`/`din1_WIDTH`/`dout_WIDTH` = 16.
  - `din0`=`in_coef` and `din1`=qt[wr_k].
- Everything else is inline: state register, counters, quant table and block buffer.

## Test plan
- Reset then 64 coefs all 1, qt default → 64 outputs all 1, `out_idx` 0..63, `out_last` only at 63, then `in_ready`=1.
- Load qt[k]=16, stream coef k=2 value -3, others 0 → output at `out_idx`=8 is 0xFFD0 and all others 0.
- Coef k=0 = 300, qt[0]=300 → output idx 0 = 0x5F90, confirming wrap.
- Random `out_ready` with 30% stalls → `out_coef` and `out_idx` stable while stalled; sequence unchanged.
- `ap_rst_n` low after 20 accepts → `in_ready`=1 and `out_valid`=0 immediately. A fresh block decodes correctly with qt=1.
- `qt_we` to index 5 in the same cycle as the accept of k=5 → old entry used for that product; next block uses the new entry.
